bus_slave_resp: RTL and testbench

Bus responder that terminates the shared-bus protocol driven by CPU-side bus masters on behalf of a local synchronous RAM or register array.
- Decodes chip select plus address strobe and latches the request.
- Inserts a programmable number of wait states, then performs one access on the local memory port.
- Returns read data and a one-cycle active-low ready.
- One instance sits behind each memory-mapped slave slot on the bus.

---
 rtl/bus_slave_resp_pkg.sv | 25 ++
 rtl/bus_slave_resp_if.sv | 27 ++
 rtl/bus_wait_cnt.sv | 27 ++
 rtl/bus_slave_resp.sv | 112 +++++++++++
 tb/tb_bus_slave_resp.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus_slave_resp_pkg.sv
// Shared bus encodings and the slave responder state encoding.
// Imported by the bus slave responder and its wait-state counter.
package bus_slave_resp_pkg;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned WORD_DATA_W = 32;
  localparam int unsigned WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    SLV_IDLE   = 2'd0,
    SLV_WAIT   = 2'd1,
    SLV_ACCESS = 2'd2,
    SLV_READY  = 2'd3
  } slv_state_e;

  function automatic logic is_request(logic cs_, logic as_);
    return (cs_ == ENABLE_) && (as_ == ENABLE_);
  endfunction

endpackage

// File: rtl/bus_slave_resp_if.sv
// Shared-bus slave slot signals: master drives the request, slave returns data and ready.
interface bus_slave_resp_if
  import bus_slave_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = WORD_ADDR_W,
  parameter int unsigned DATA_W = WORD_DATA_W
);

  logic              s_cs_;
  logic              s_as_;
  logic              s_rw;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wr_data;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_rdy_;

  modport master (
    output s_cs_, s_as_, s_rw, s_addr, s_wr_data,
    input  s_rd_data, s_rdy_
  );

  modport slave (
    input  s_cs_, s_as_, s_rw, s_addr, s_wr_data,
    output s_rd_data, s_rdy_
  );

endinterface

// File: rtl/bus_wait_cnt.sv
// Loadable 4-bit down-counter; last flags a count of one so the owner can leave its wait state.
module bus_wait_cnt
  import bus_slave_resp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  last
);

  logic [WAIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/bus_slave_resp.sv
// Shared-bus slave responder: latches a request, waits WAIT_CYCLES, does one local
// memory access and returns a one-cycle active-low ready with gated read data.
module bus_slave_resp
  import bus_slave_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = WORD_ADDR_W,
  parameter int unsigned DATA_W      = WORD_DATA_W,
  parameter int unsigned MEM_ADDR_W  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_slave_resp_if.slave       bus,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wr_data,
  input  logic [DATA_W-1:0]     mem_rd_data
);

  if (WAIT_CYCLES > (1 << WAIT_CNT_W) - 1) begin : gen_bad_wait
    $error("bus_slave_resp: WAIT_CYCLES must be 0..15");
  end
  if (MEM_ADDR_W > ADDR_W) begin : gen_bad_addr
    $error("bus_slave_resp: MEM_ADDR_W must not exceed ADDR_W");
  end

  slv_state_e            state_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  rw_q;
  logic [DATA_W-1:0]     data_q;
  logic                  en_q;
  logic                  we_q;
  logic                  rdy_q;

  logic request;
  logic cnt_load;
  logic cnt_last;

  assign request  = is_request(bus.s_cs_, bus.s_as_);
  assign cnt_load = (state_q == SLV_IDLE) && request && (WAIT_CYCLES != 0);

  bus_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
    .dec      (state_q == SLV_WAIT),
    .last     (cnt_last)
  );

  // Strobes are registered alongside the state so they never glitch on transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SLV_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      rdy_q   <= DISABLE_;
    end else begin
      en_q  <= 1'b0;
      we_q  <= 1'b0;
      rdy_q <= DISABLE_;
      case (state_q)
        SLV_IDLE: begin
          if (request) begin
            addr_q <= bus.s_addr[MEM_ADDR_W-1:0];
            rw_q   <= bus.s_rw;
            data_q <= bus.s_wr_data;
            if (WAIT_CYCLES == 0) begin
              state_q <= SLV_ACCESS;
              en_q    <= 1'b1;
              we_q    <= (bus.s_rw == WRITE);
            end else begin
              state_q <= SLV_WAIT;
            end
          end
        end
        SLV_WAIT: begin
          if (cnt_last) begin
            state_q <= SLV_ACCESS;
            en_q    <= 1'b1;
            we_q    <= (rw_q == WRITE);
          end
        end
        SLV_ACCESS: begin
          state_q <= SLV_READY;
          rdy_q   <= ENABLE_;
        end
        SLV_READY: state_q <= SLV_IDLE;
        default:   state_q <= SLV_IDLE;
      endcase
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wr_data = data_q;
  assign mem_en      = en_q;
  assign mem_we      = we_q;

  assign bus.s_rdy_ = rdy_q;
  // Zero outside a read ready so several slaves can be OR-merged on the bus.
  assign bus.s_rd_data = ((rdy_q == ENABLE_) && (rw_q == READ)) ? mem_rd_data : '0;

  if (ADDR_W > MEM_ADDR_W) begin : gen_unused_addr
    logic unused_addr;
    assign unused_addr = ^bus.s_addr[ADDR_W-1:MEM_ADDR_W];
  end

endmodule

// File: tb/tb_bus_slave_resp.sv
// Scoreboard bench for bus_slave_resp: three instances with 0, 3 and 5 wait states.
module tb_bus_slave_resp;

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rd;
    int          cyc;
  } rdy_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [3];
  logic        cs_n  [3];
  logic        as_n  [3];
  logic        rw_b  [3];
  logic [29:0] addr_b[3];
  logic [31:0] wd_b  [3];
  logic        rdy_n [3];
  logic [31:0] rd_b  [3];
  logic        en    [3];
  logic        we    [3];
  logic [9:0]  maddr [3];
  logic [31:0] mwd   [3];
  logic [31:0] mrd   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    bus_slave_resp_if #(.ADDR_W(30), .DATA_W(32)) bus_if ();
    assign bus_if.s_cs_     = cs_n[g];
    assign bus_if.s_as_     = as_n[g];
    assign bus_if.s_rw      = rw_b[g];
    assign bus_if.s_addr    = addr_b[g];
    assign bus_if.s_wr_data = wd_b[g];
    assign rdy_n[g]         = bus_if.s_rdy_;
    assign rd_b[g]          = bus_if.s_rd_data;

    bus_slave_resp #(
      .ADDR_W      (30),
      .DATA_W      (32),
      .MEM_ADDR_W  (10),
      .WAIT_CYCLES (W)
    ) u_dut (
      .clk         (clk),
      .reset       (rst_n[g]),
      .bus         (bus_if),
      .mem_addr    (maddr[g]),
      .mem_en      (en[g]),
      .mem_we      (we[g]),
      .mem_wr_data (mwd[g]),
      .mem_rd_data (mrd[g])
    );
  end

  // Synchronous RAM, one-cycle read latency, read data held until the next access.
  logic [31:0] ram [3][1024];
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n[d]) begin
        ram[d][5] <= 32'hDEAD_BEEF;
      end else if (en[d]) begin
        if (we[d]) ram[d][maddr[d]] <= mwd[d];
        else       mrd[d] <= ram[d][maddr[d]];
      end
    end
  end

  mem_exp_t mem_q[3][$];
  rdy_exp_t rdy_q[3][$];
  int checks = 0;
  int passes = 0;
  int gate_err = 0;
  int en_cnt[3];
  int rdy_cnt[3];
  mem_exp_t mm;
  rdy_exp_t rr;

  function automatic int wait_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever a DUT shows mem_en or ready.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rdy_n[d] === 1'b1 && rd_b[d] !== 32'h0) gate_err++;
      if (en[d] === 1'b1) begin
        en_cnt[d]++;
        checks++;
        if (mem_q[d].size() == 0) begin
          $display("FAIL access dut%0d: got mem_en at cycle %0d want none", d, cyc);
        end else begin
          mm = mem_q[d].pop_front();
          if (we[d] === mm.we && maddr[d] === mm.addr && cyc == mm.cyc &&
              (!mm.we || mwd[d] === mm.wd)) begin
            passes++;
          end else begin
            $display("FAIL access dut%0d: got cyc=%0d we=%b addr=%h wd=%h want cyc=%0d we=%b addr=%h wd=%h",
                     d, cyc, we[d], maddr[d], mwd[d], mm.cyc, mm.we, mm.addr, mm.wd);
          end
        end
      end
      if (rdy_n[d] === 1'b0) begin
        rdy_cnt[d]++;
        checks++;
        if (rdy_q[d].size() == 0) begin
          $display("FAIL ready dut%0d: got ready at cycle %0d want none", d, cyc);
        end else begin
          rr = rdy_q[d].pop_front();
          if (rd_b[d] === rr.rd && cyc == rr.cyc) passes++;
          else $display("FAIL ready dut%0d: got cyc=%0d rd=%h want cyc=%0d rd=%h",
                        d, cyc, rd_b[d], rr.cyc, rr.rd);
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one request cycle starting at a negedge; returns at the next negedge.
  task automatic issue(int d, logic rw, logic [29:0] a, logic [31:0] wdat,
                       logic [31:0] exp_rd, bit expect_resp);
    cs_n[d] = 1'b0; as_n[d] = 1'b0; rw_b[d] = rw; addr_b[d] = a; wd_b[d] = wdat;
    if (expect_resp) begin
      mem_q[d].push_back('{we: !rw, addr: a[9:0], wd: wdat, cyc: cyc + 1 + wait_of(d)});
      rdy_q[d].push_back('{rd: rw ? exp_rd : 32'h0, cyc: cyc + 2 + wait_of(d)});
    end
    @(negedge clk);
    cs_n[d] = 1'b1; as_n[d] = 1'b1;
  endtask

  task automatic chk_reset_outputs(int d, string tag);
    chk({tag, "_rdy_n"},  32'(rdy_n[d]), 32'h1);
    chk({tag, "_rd"},     rd_b[d],       32'h0);
    chk({tag, "_en"},     32'(en[d]),    32'h0);
    chk({tag, "_we"},     32'(we[d]),    32'h0);
    chk({tag, "_maddr"},  32'(maddr[d]), 32'h0);
    chk({tag, "_mwd"},    mwd[d],        32'h0);
  endtask

  int e0, r0;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; cs_n[d] = 1'b1; as_n[d] = 1'b1; rw_b[d] = 1'b1;
      addr_b[d] = '0; wd_b[d] = '0; en_cnt[d] = 0; rdy_cnt[d] = 0;
    end
    idle(3);
    chk_reset_outputs(0, "rst");
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    idle(2);

    // W=0 read, write, read-back
    issue(0, 1'b1, 30'h005, 32'h0, 32'hDEAD_BEEF, 1'b1); idle(3);
    issue(0, 1'b0, 30'h010, 32'h1234_5678, 32'h0, 1'b1); idle(3);
    issue(0, 1'b1, 30'h010, 32'h0, 32'h1234_5678, 1'b1); idle(3);

    // Strobe without chip select: no activity
    e0 = en_cnt[0]; r0 = rdy_cnt[0];
    cs_n[0] = 1'b1; as_n[0] = 1'b0;
    idle(10);
    as_n[0] = 1'b1;
    idle(1);
    chk("nocs_en_count",  32'(en_cnt[0] - e0),  32'h0);
    chk("nocs_rdy_count", 32'(rdy_cnt[0] - r0), 32'h0);

    // Master abandons the strobe and changes data after acceptance
    issue(0, 1'b0, 30'h020, 32'hA5A5_A5A5, 32'h0, 1'b1);
    wd_b[0] = 32'hFFFF_0000; addr_b[0] = 30'h3FF; rw_b[0] = 1'b1;
    idle(2);
    issue(0, 1'b1, 30'h020, 32'h0, 32'hA5A5_A5A5, 1'b1); idle(3);

    // Back-to-back at minimum spacing
    issue(0, 1'b1, 30'h005, 32'h0, 32'hDEAD_BEEF, 1'b1); idle(2);
    issue(0, 1'b1, 30'h010, 32'h0, 32'h1234_5678, 1'b1); idle(3);

    // W=3 read
    issue(1, 1'b1, 30'h005, 32'h0, 32'hDEAD_BEEF, 1'b1); idle(7);

    // W=5: reset asserted while waiting aborts the access
    e0 = en_cnt[2]; r0 = rdy_cnt[2];
    issue(2, 1'b1, 30'h005, 32'h0, 32'h0, 1'b0);
    idle(1);
    rst_n[2] = 1'b0;
    #1;
    chk_reset_outputs(2, "async");
    @(negedge clk);
    rst_n[2] = 1'b1;
    idle(12);
    chk("abort_en_count",  32'(en_cnt[2] - e0),  32'h0);
    chk("abort_rdy_count", 32'(rdy_cnt[2] - r0), 32'h0);
    issue(2, 1'b1, 30'h005, 32'h0, 32'hDEAD_BEEF, 1'b1); idle(9);

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("pending_access_dut%0d", d), 32'(mem_q[d].size()), 32'h0);
      chk($sformatf("pending_ready_dut%0d", d),  32'(rdy_q[d].size()), 32'h0);
    end
    chk("rd_data_gating_violations", 32'(gate_err), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
